// File: rtl/logn_pkg.sv
// rtl/logn_pkg.sv - widths, ln(1+2^-k) table, LN2 and FSM states for the logn unit
package logn_pkg;

    localparam int X0_W   = 10;
    localparam int Y_W    = 12;
    localparam int ACC_W  = 16;
    localparam int XI_W   = 16;
    localparam int N_ITER = 8;
    localparam int LN2    = 2839;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_DONE
    } state_t;

    // ln(1 + 2^-k) in Q.12, rounded
    function automatic logic [ACC_W-1:0] ln_step(input logic [3:0] k);
        case (k)
            4'd1:    ln_step = ACC_W'(1661);
            4'd2:    ln_step = ACC_W'(914);
            4'd3:    ln_step = ACC_W'(482);
            4'd4:    ln_step = ACC_W'(248);
            4'd5:    ln_step = ACC_W'(126);
            4'd6:    ln_step = ACC_W'(64);
            4'd7:    ln_step = ACC_W'(32);
            4'd8:    ln_step = ACC_W'(16);
            default: ln_step = '0;
        endcase
    endfunction

endpackage

// File: rtl/logn_if.sv
// rtl/logn_if.sv - request/result handshake bundle of the logn unit
interface logn_if;
    import logn_pkg::*;

    logic            start;
    logic [X0_W-1:0] x0;
    logic [Y_W-1:0]  y;
    logic            done;
    logic            busy;
    logic            err;

    modport master (output start, x0, input y, done, busy, err);
    modport slave  (input start, x0, output y, done, busy, err);

endinterface

// File: rtl/logn_lzc.sv
// rtl/logn_lzc.sv - leading-zero count and shift bringing x0 into [0x080, 0x100]
module logn_lzc
    import logn_pkg::*;
(
    input  logic [X0_W-2:0] v,
    output logic [2:0]      s,
    output logic [X0_W-2:0] m
);

    always_comb begin
        s = '0;
        if (!v[X0_W-2]) begin
            // ascending scan: the highest set bit wins
            for (int i = 0; i < 8; i++) begin
                if (v[i]) s = 3'(7 - i);
            end
        end
        m = v << s;
    end

endmodule

// File: rtl/logn.sv
// rtl/logn.sv - iterative ln(x0) for x0 in (0,1] by multiplicative normalisation
// Optional pre-normaliser enabled by LOGN_PRENORM_EN.
module logn
    import logn_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    logn_if.slave bus
);

    state_t           state, state_nxt;
    logic [X0_W-1:0]  x0_q;
    logic [XI_W-1:0]  x;
    logic [ACC_W-1:0] acc;
    logic [3:0]       k;
    logic             err_pend;
    logic [Y_W-1:0]   y_q;
    logic             done_q;
    logic             err_q;
    logic             accept;
    logic             dom_err;
    logic [XI_W:0]    x_try;
    logic             step_ok;
    logic [Y_W-1:0]   y_rnd;

`ifdef LOGN_PRENORM_EN
    logic [2:0]       norm_s;
    logic [X0_W-2:0]  norm_m;

    logn_lzc u_lzc (
        .v (x0_q[X0_W-2:0]),
        .s (norm_s),
        .m (norm_m)
    );
`endif

    // the done cycle still counts as busy, so start is ignored there
    assign accept = (state == S_IDLE) && bus.start && !done_q;

`ifdef LOGN_PRENORM_EN
    assign dom_err = (x0_q == '0) || x0_q[X0_W-1] || (x0_q > X0_W'(10'h100));
`else
    assign dom_err = (x0_q == '0) || x0_q[X0_W-1] || (x0_q > X0_W'(10'h100))
                     || (x0_q < X0_W'(10'h080));
`endif

    assign x_try   = {1'b0, x} + {1'b0, x >> k};
    assign step_ok = x_try <= 17'h0_8000;
    assign y_rnd   = Y_W'((acc + ACC_W'(8)) >> 4);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_NORM;
            S_NORM:  state_nxt = dom_err ? S_DONE : S_ITER;
            S_ITER:  if (k == 4'(N_ITER)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x0_q     <= '0;
            x        <= '0;
            acc      <= '0;
            k        <= '0;
            err_pend <= 1'b0;
            y_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x0_q <= bus.x0;
                        acc  <= '0;
                    end
                end
                S_NORM: begin
                    k        <= 4'd1;
                    err_pend <= dom_err;
`ifdef LOGN_PRENORM_EN
                    x   <= {norm_m, 7'b0};
                    acc <= ACC_W'(0) - ACC_W'(norm_s) * ACC_W'(LN2);
`else
                    x   <= {x0_q[X0_W-2:0], 7'b0};
`endif
                end
                S_ITER: begin
                    if (step_ok) begin
                        x   <= x_try[XI_W-1:0];
                        acc <= acc - ln_step(k);
                    end
                    k <= k + 4'd1;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    err_q  <= err_pend;
                    y_q    <= err_pend ? '0 : y_rnd;
                end
                default: ;
            endcase
        end
    end

    assign bus.y    = y_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.busy = (state != S_IDLE) || done_q;

endmodule

// File: tb/tb_logn.sv
// tb/tb_logn.sv - randomized check of logn against an arithmetic reference and ln()
module tb_logn;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   ln_tab [8] = '{1661, 914, 482, 248, 126, 64, 32, 16};

    logn_if bus ();

    logn dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic void model(input int xv, output int ey, output bit eerr);
        int s, m, xi, a, t;
        eerr = (xv == 0) || (xv > 256);
`ifndef LOGN_PRENORM_EN
        if (xv < 128) eerr = 1'b1;
`endif
        ey = 0;
        if (eerr) return;
        m = xv;
        s = 0;
        while (m < 128) begin
            m = m * 2;
            s++;
        end
        xi = m * 128;
        a  = -s * 2839;
        for (int k = 1; k <= 8; k++) begin
            t = xi + (xi >> k);
            if (t <= 32768) begin
                xi = t;
                a  = a - ln_tab[k-1];
            end
        end
        ey = (a + 8) >>> 4;
    endfunction

    // mode 0: plain, 1: second start at t+3, 2: reset at t+5
    task automatic run_op(input logic [9:0] v, input int mode);
        int  ey, lat, yv, ref_y, dev;
        bit  eerr, seen;
        real r;
        model(int'(v), ey, eerr);
        bus.start = 1'b1;
        bus.x0    = v;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x0    = 10'($urandom);
        check("busy_on", int'(bus.busy), 1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (mode == 1 && lat == 2) begin
                bus.start = 1'b1;
                bus.x0    = v ^ 10'h0C3;
            end
            if (mode == 2 && lat == 4) rst = 1'b1;
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            if (mode == 2 && lat == 5) begin
                rst = 1'b0;
                check("rst_y", int'(bus.y), 0);
                check("rst_done", int'(bus.done), 0);
                check("rst_busy", int'(bus.busy), 0);
                check("rst_err", int'(bus.err), 0);
                check("rst_no_done", int'(seen), 0);
                return;
            end
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
        if (!seen) return;
        yv = $signed(bus.y);
        check("latency", lat, eerr ? 2 : 10);
        check("err", int'(bus.err), int'(eerr));
        check("y", yv, ey);
        check("busy_done_cycle", int'(bus.busy), 1);
        if (!eerr) begin
            r     = $ln(real'(v) / 256.0) * 256.0;
            ref_y = int'(r);
            dev   = yv - ref_y;
            check("accuracy_dev", (dev >= -2 && dev <= 2) ? 0 : dev, 0);
        end
        @(negedge clk);
        check("done_pulse", int'(bus.done), 0);
        check("busy_off", int'(bus.busy), 0);
    endtask

    initial begin
        logic [9:0] v;
        bus.start = 1'b0;
        bus.x0    = '0;
        repeat (3) @(negedge clk);
        check("reset_y", int'(bus.y), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_err", int'(bus.err), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(10'h080, 0);
        run_op(10'h100, 0);
        run_op(10'h0C0, 0);
        run_op(10'h001, 0);
        run_op(10'h000, 0);
        run_op(10'h200, 0);
        run_op(10'h101, 0);
        run_op(10'h07F, 0);
        run_op(10'h3FF, 0);
        run_op(10'h0A5, 1);
        run_op(10'h0E0, 2);
        run_op(10'h090, 0);

        repeat (60) begin
            if ($urandom_range(0, 3) == 0) v = 10'($urandom_range(0, 1023));
            else                          v = 10'($urandom_range(1, 256));
            run_op(v, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/logn.md
LOGN -- requirements
Module: logn

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-004 SHALL have port x0, input, 10 bits: operand; two's-complement Q1.8, scale factor 2^-8; valid codes 0x001..0x100, i.e. (0,1].
REQ-005 SHALL have port y, output, 12 bits: ln(x0) as signed Q3.8; held until the next accepted start.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse when y/err become valid.
REQ-007 SHALL have port busy, output, 1 bit: high from start acceptance up to and including the done cycle.
REQ-008 SHALL have port err, output, 1 bit: domain error flag, valid with done.

Function
REQ-009 SHALL implement the FSM states IDLE, NORM, ITER and DONE, with transitions IDLE->NORM on start, NORM->ITER, ITER->DONE after k=8, and DONE->IDLE.
REQ-010 SHALL, in IDLE with start=1 at edge t, latch x0 and clear the accumulator.
REQ-011 SHALL, in NORM, check the domain and, when enabled, normalise x0 (see Configuration).
REQ-012 SHALL load internal x as unsigned Q1.15 (x0 shifted left 7).
REQ-013 SHALL hold the accumulator acc as signed 16-bit Q3.12.
REQ-014 SHALL, in ITER cycle k (k=1..8), take the step when x + (x>>k) <= 0x8000 (1.0): x <= x + (x>>k) and acc <= acc - LN[k].
REQ-015 SHALL, when the step is not taken, leave x and acc unchanged.
REQ-016 SHALL use LN[1..8] = 1661, 914, 482, 248, 126, 64, 32, 16 (Q.12, rounded ln(1+2^-k)).
REQ-017 SHALL produce the result by round-half-up: y = (acc + 8) >>> 4.
REQ-018 SHALL have a latency for a valid operand of done high in the cycle following edge t+10; y, err and done all update at edge t+10.
REQ-019 SHALL treat x0 == 0, x0[9] == 1 or x0 > 0x100 as a domain error: NORM->DONE directly, done at edge t+2, err=1, y=0.
REQ-020 SHALL compute x0 == 0x100 through the normal path, giving y=0 and err=0.
REQ-021 SHALL ignore start while busy; x0 changes after acceptance have no effect.
REQ-022 SHALL accept a new start if start is high in the cycle after done (IDLE), i.e. back-to-back operation with one idle cycle.
REQ-023 SHALL keep the accuracy of y within ±2 LSB of round(ln(x0)*256) for all valid non-error operands.

Reset
REQ-024 SHALL, with rst=1 at an edge, force IDLE, y=0, done=0, busy=0, err=0, acc=0 and x=0.
REQ-025 SHALL let rst take priority over start and abort any operation in progress without producing a done pulse.

Configuration
REQ-026 SHALL provide the macro LOGN_PRENORM_EN.
REQ-027 SHALL, with LOGN_PRENORM_EN defined, find s = leading-zero count so that m = x0<<s lies in [0x080, 0x100] (s = 0..7) in NORM, set x from m and set acc = -s*LN2, where LN2 = 2839 (Q.12); the whole (0,1] domain is then valid.
REQ-028 SHALL, with LOGN_PRENORM_EN undefined, treat 0x001..0x07F as a domain error per REQ-019, with no normaliser logic present.
REQ-029 SHALL keep latency and port list identical in both builds.

Structure
REQ-030 SHALL place the following in package logn_pkg: the width constants (X0_W=10, Y_W=12, ACC_W=16, XI_W=16), the LN table, LN2, the iteration count 8, and the FSM state enum.
REQ-031 SHALL put the normaliser in a sub-module logn_lzc (combinational leading-zero count and shift), instantiated only under LOGN_PRENORM_EN.

Verification
REQ-032 SHALL cover: x0=0x080 (0.5) -> done at t+10, y=-177 (0xF4F), err=0.
REQ-033 SHALL cover: x0=0x100 (1.0) -> y=0, err=0; x0=0x0C0 (0.75) -> y=-74 ±1.
REQ-034 SHALL cover: x0=0x001, macro defined -> y=-1419 ±2; macro undefined -> done at t+2, err=1, y=0.
REQ-035 SHALL cover: x0=0x000 and x0=0x200 -> done at t+2, err=1, y=0.
REQ-036 SHALL cover: start pulsed again at t+3 with different x0 -> ignored, and the result equals that of the first operand.
REQ-037 SHALL cover: rst at t+5 -> all outputs 0 next cycle, no done pulse; a fresh start afterwards completes normally.
